// File: rtl/lcd_pkg.sv
// Shared timing defaults, phase encoding and test-pattern constants for the LCD timing generator.
package lcd_pkg;

  localparam int unsigned LCD_H_ACTIVE = 480;
  localparam int unsigned LCD_H_FP     = 2;
  localparam int unsigned LCD_H_SYNC   = 41;
  localparam int unsigned LCD_H_BP     = 2;
  localparam int unsigned LCD_V_ACTIVE = 272;
  localparam int unsigned LCD_V_FP     = 2;
  localparam int unsigned LCD_V_SYNC   = 10;
  localparam int unsigned LCD_V_BP     = 2;

  localparam int unsigned LCD_MIN_CNT_W = 10;
  localparam int unsigned LCD_CELL      = 24;
  localparam logic [7:0]  LCD_TP_LEVEL  = 8'd150;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } lcd_phase_e;

  function automatic int unsigned lcd_cnt_width(input int unsigned len);
    int unsigned w;
    w = $clog2(len);
    return (w < LCD_MIN_CNT_W) ? LCD_MIN_CNT_W : w;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel request/data and panel-side signals of the LCD timing generator.
interface lcd_timing_gen_if;

  logic       pix_req;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic [9:0] lcd_x;
  logic [9:0] lcd_y;
  logic [7:0] lcd_r;
  logic [7:0] lcd_g;
  logic [7:0] lcd_b;
  logic       lcd_hsync_n;
  logic       lcd_vsync_n;
  logic       lcd_de;
  logic       frame_start;

  modport master (
    output pix_req, lcd_x, lcd_y, lcd_r, lcd_g, lcd_b,
    output lcd_hsync_n, lcd_vsync_n, lcd_de, frame_start,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_req, lcd_x, lcd_y, lcd_r, lcd_g, lcd_b,
    input  lcd_hsync_n, lcd_vsync_n, lcd_de, frame_start,
    output pix_r, pix_g, pix_b
  );

endinterface

// File: rtl/lcd_phase_cnt.sv
// Generic SYNC/BP/ACT/FP phase counter; count restarts at 0 on every phase change.
module lcd_phase_cnt
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC = 1,
  parameter int unsigned BP   = 1,
  parameter int unsigned ACT  = 1,
  parameter int unsigned FP   = 1,
  parameter int unsigned CntW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv_i,
  output lcd_phase_e      phase_o,
  output logic [CntW-1:0] cnt_o,
  output logic            last_o,
  output lcd_phase_e      nxt_phase_o
);

  lcd_phase_e      phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] last_cnt;

  always_comb begin
    last_cnt = CntW'(SYNC - 1);
    case (phase_q)
      PH_BP:   last_cnt = CntW'(BP - 1);
      PH_ACT:  last_cnt = CntW'(ACT - 1);
      PH_FP:   last_cnt = CntW'(FP - 1);
      default: last_cnt = CntW'(SYNC - 1);
    endcase
  end

  assign last_o = (cnt_q == last_cnt);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (adv_i) begin
      if (last_o) begin
        cnt_d = '0;
        case (phase_q)
          PH_SYNC: phase_d = PH_BP;
          PH_BP:   phase_d = PH_ACT;
          PH_ACT:  phase_d = PH_FP;
          default: phase_d = PH_SYNC;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_SYNC;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_o     = phase_q;
  assign cnt_o       = cnt_q;
  assign nxt_phase_o = phase_d;

endmodule

// File: rtl/lcd_timing_gen.sv
// 480x272 LCD timing generator with one-cycle-ahead pixel request.
// Optional checkerboard test pattern enabled by defining LCD_TESTPAT_EN.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
  parameter int unsigned H_FP     = LCD_H_FP,
  parameter int unsigned H_SYNC   = LCD_H_SYNC,
  parameter int unsigned H_BP     = LCD_H_BP,
  parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
  parameter int unsigned V_FP     = LCD_V_FP,
  parameter int unsigned V_SYNC   = LCD_V_SYNC,
  parameter int unsigned V_BP     = LCD_V_BP
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LCD_TESTPAT_EN
  input  logic             test_mode,
`endif
  input  logic             en,
  lcd_timing_gen_if.master bus
);

  localparam int unsigned HCntW = lcd_cnt_width(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam int unsigned VCntW = lcd_cnt_width(V_SYNC + V_BP + V_ACTIVE + V_FP);

  // The phase counters run one cycle ahead: they hold the position the registered
  // outputs will show after the next edge, so their next state predicts pix_req.
  lcd_phase_e       h_phase, h_nxt_phase, v_phase, v_nxt_phase;
  logic [HCntW-1:0] h_cnt;
  logic [VCntW-1:0] v_cnt;
  logic             h_last, v_last;
  logic             go, line_end, frame_end, act_now, act_nxt, tp_eff;
  logic             run_q, run_d;

  logic       pix_req_q, pix_req_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d;
  logic       de_q, de_d, fs_q, fs_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // A frame in progress always runs to its end; a new one starts only with en.
  assign go        = run_q | en;
  assign line_end  = (h_phase == PH_FP) & h_last;
  assign frame_end = line_end & (v_phase == PH_FP) & v_last;
  assign act_now   = (h_phase == PH_ACT) & (v_phase == PH_ACT);
  assign act_nxt   = (h_nxt_phase == PH_ACT) & (v_nxt_phase == PH_ACT);
  assign run_d     = go ? ~frame_end : run_q;

  lcd_phase_cnt #(
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .ACT  (H_ACTIVE),
    .FP   (H_FP),
    .CntW (HCntW)
  ) u_h_cnt (
    .clk         (clk),
    .rst         (rst),
    .adv_i       (go),
    .phase_o     (h_phase),
    .cnt_o       (h_cnt),
    .last_o      (h_last),
    .nxt_phase_o (h_nxt_phase)
  );

  lcd_phase_cnt #(
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .ACT  (V_ACTIVE),
    .FP   (V_FP),
    .CntW (VCntW)
  ) u_v_cnt (
    .clk         (clk),
    .rst         (rst),
    .adv_i       (go & line_end),
    .phase_o     (v_phase),
    .cnt_o       (v_cnt),
    .last_o      (v_last),
    .nxt_phase_o (v_nxt_phase)
  );

`ifdef LCD_TESTPAT_EN
  logic tp_q, tp_d, tp_red;

  always_comb begin
    tp_d = tp_q;
    if (go && !run_q) tp_d = test_mode;
  end
  assign tp_eff = tp_d;
  assign tp_red = (((h_cnt[9:0] / 10'(LCD_CELL)) ^ (v_cnt[9:0] / 10'(LCD_CELL)))
                   & 10'd1) == 10'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tp_q <= 1'b0;
    else     tp_q <= tp_d;
  end
`else
  assign tp_eff = 1'b0;
`endif

  always_comb begin
    pix_req_d = 1'b0;
    hs_n_d    = 1'b1;
    vs_n_d    = 1'b1;
    de_d      = 1'b0;
    fs_d      = 1'b0;
    x_d       = '0;
    y_d       = '0;
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    if (go) begin
      fs_d      = ~run_q;
      hs_n_d    = (h_phase != PH_SYNC);
      vs_n_d    = (v_phase != PH_SYNC);
      de_d      = act_now;
      pix_req_d = act_nxt & ~tp_eff;
      if (act_now) begin
        x_d = h_cnt[9:0];
        y_d = v_cnt[9:0];
        r_d = bus.pix_r;
        g_d = bus.pix_g;
        b_d = bus.pix_b;
`ifdef LCD_TESTPAT_EN
        if (tp_eff) begin
          r_d = tp_red ? LCD_TP_LEVEL : 8'd0;
          g_d = '0;
          b_d = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= 1'b0;
      pix_req_q <= 1'b0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      run_q     <= run_d;
      pix_req_q <= pix_req_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign bus.pix_req     = pix_req_q;
  assign bus.lcd_hsync_n = hs_n_q;
  assign bus.lcd_vsync_n = vs_n_q;
  assign bus.lcd_de      = de_q;
  assign bus.frame_start = fs_q;
  assign bus.lcd_x       = x_q;
  assign bus.lcd_y       = y_q;
  assign bus.lcd_r       = r_q;
  assign bus.lcd_g       = g_q;
  assign bus.lcd_b       = b_q;

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Video timing generator for the 480x272 RGB LCD panel. Produces hsync/vsync/data-enable and the active pixel coordinates, and pulls pixel colour from an upstream source with a one-cycle-ahead request. Its registered outputs feed the LCD panel model (`x`, `y`, `r`, `g`, `b`) directly, so it sits immediately upstream of the LCD.

## Interface
Parameters:
- `H_ACTIVE`, 480: visible pixels per line.
- `H_FP`, 2: horizontal front porch in clocks.
- `H_SYNC`, 41: hsync width in clocks.
- `H_BP`, 2: horizontal back porch in clocks.
- `V_ACTIVE`, 272: visible lines per frame.
- `V_FP`, 2: vertical front porch in lines.
- `V_SYNC`, 10: vsync width in lines.
- `V_BP`, 2: vertical back porch in lines.

Ports:
- `clk`, input, 1: pixel clock. Everything is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: run enable.
- `pix_req`, output, 1: request upstream pixel data this cycle.
- `pix_r`, `pix_g`, `pix_b`, input, 8 each: upstream colour, sampled when `pix_req` is 1.
- `lcd_x`, output, 10: active column.
- `lcd_y`, output, 10: active row.
- `lcd_r`, `lcd_g`, `lcd_b`, output, 8 each: panel colour.
- `lcd_hsync_n`, `lcd_vsync_n`, output, 1 each: active-low syncs.
- `lcd_de`, output, 1: data enable.
- `frame_start`, output, 1: one-cycle pulse in the first cycle of each frame.

## Operation
- Horizontal FSM with states `H_SYNC → H_BP → H_ACT → H_FP → H_SYNC`. The state durations are the parameters, so a line is 525 clocks by default.
- Vertical FSM with states `V_SYNC → V_BP → V_ACT → V_FP`. It advances one line count when the H_FP last cycle ends, so a frame is 286 lines by default.
- `lcd_de` is 1 only when both FSMs are in their ACT state.
- `lcd_x` counts 0..H_ACTIVE-1 and `lcd_y` counts 0..V_ACTIVE-1 while `lcd_de` is 1. When `lcd_de` is 0, both are forced to 0.
- `lcd_r`, `lcd_g` and `lcd_b` are forced to 0 when `lcd_de` is 0.
- `lcd_hsync_n` is 0 in `H_SYNC`. `lcd_vsync_n` is 0 in every clock of the `V_SYNC` lines.
- Idle state: both FSMs are parked at the start of `H_SYNC`/`V_SYNC` with all outputs at their reset values.
- Start: when idle and `en` = 1, the next cycle is frame cycle 0, with `frame_start` = 1 and both syncs low.
- Stop: if `en` = 0 mid-frame, the frame completes to the end of the last `V_FP` line, then the block idles. It never truncates a frame.
- Counters in both FSMs wrap to 0 on every state change. Counter widths are sized from the parameters, with a minimum of 10 bits.

## Timing
- Reset values: `pix_req` = 0, `lcd_x` = 0, `lcd_y` = 0, `lcd_r`/`lcd_g`/`lcd_b` = 0, `lcd_hsync_n` = 1, `lcd_vsync_n` = 1, `lcd_de` = 0, `frame_start` = 0. Both FSMs are idle.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Operation restarts from frame cycle 0 on the first edge after release if `en` = 1.
- All outputs are registered.
- Pixel handshake:
  - `pix_req` is high in cycle N exactly when `lcd_de` will be high in cycle N+1.
  - Upstream must hold valid `pix_*` in cycle N. The block captures them at the end of N and shows them on `lcd_*` in N+1 together with the matching `lcd_x`/`lcd_y`.
  - There is no backpressure: upstream must always supply data when requested.
- `pix_req` rises in the last `H_BP` cycle of an active line and falls in the cycle before the first `H_FP` cycle. That gives exactly H_ACTIVE requests per active line and H_ACTIVE×V_ACTIVE requests per frame.
- Frame period at defaults: 525×286 = 150150 clocks.

## Configuration
- Macro: `LCD_TESTPAT_EN`.
- When defined:
  - An extra input port `test_mode` (1 bit) exists.
  - When `test_mode` = 1, `pix_req` stays 0 and the colour comes from an internal checkerboard.
  - A pixel is red (150,0,0) when `(lcd_x/24) XOR (lcd_y/24)` is even in its LSB, and black (0,0,0) otherwise.
  - `test_mode` is sampled only at `frame_start`, so the mode never changes mid-frame.
- When undefined: the port and the pattern logic are absent, and colour always comes from `pix_*`.

## Structure
- Package `lcd_pkg` holds:
  - the default timing constants (`LCD_H_ACTIVE` etc.);
  - the 2-bit phase enum shared by both FSMs (`PH_SYNC`, `PH_BP`, `PH_ACT`, `PH_FP`);
  - the checkerboard constants: cell size 24 and colour 150.
- Sub-module `lcd_phase_cnt` is a generic four-phase counter with `SYNC`/`BP`/`ACT`/`FP` length parameters, an advance strobe, and outputs for phase, in-phase count and last-cycle flag. It is instantiated twice: the horizontal FSM is strobed every clock, the vertical FSM at end of line.

## Test plan
- Reset, then `en` = 1: first cycle after reset release has `frame_start` = 1 and both syncs low. `lcd_hsync_n` is low for 41 clocks. First `lcd_de` = 1 occurs at line 12 (after 10 sync + 2 BP lines), clock 43, with `lcd_x` = 0 and `lcd_y` = 0.
- Free-run for 2 frames: count exactly 150150 clocks between `frame_start` pulses, 130560 `lcd_de` cycles per frame, and `lcd_x` reaching a maximum of 479 and `lcd_y` a maximum of 271.
- Upstream drives `pix_r` = `lcd_x`[7:0] predicted from `pix_req`: every `lcd_de` cycle shows `lcd_r` == `lcd_x`[7:0], proving the one-cycle alignment.
- Deassert `en` at line 100: frame completes, `lcd_vsync_n` never falls again, and outputs hold at reset values. Reassert `en`: next cycle `frame_start` = 1.
- Assert `rst` at line 150, x = 200: outputs return to reset values at once. After release, a full frame proceeds from cycle 0.
- With `LCD_TESTPAT_EN` and `test_mode` = 1: pixel (0,0) = (150,0,0), (24,0) = (0,0,0), (24,24) = (150,0,0), and `pix_req` stays 0 all frame.
